hash_seq_ctrl: RTL and testbench

Parametrised hash sequencing controller between the Keccak core and the sampler channels (Parse/CBD instances) of the Kyber datapath. It captures the rho/sigma seed produced by the seed-expansion hash and generates absorb streams for XOF(rho,i,j) and PRF(sigma,N) with full nonce bytes. It routes the squeezed Keccak stream to one of NCH sampler channels, and returns that channel's samples and SRAM address. Unlike the previous single-flop design it has 8-bit nonces, a busy/error guard, per-channel routing and an explicit start/finish lifecycle.

---
 rtl/hash_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_hash_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_seq_ctrl.sv
// hash_seq_ctrl: sequences seed load, XOF/PRF absorb streams and squeeze routing
// between the Keccak core and NCH sampler channels.
module hash_seq_ctrl #(
  parameter int W          = 64,
  parameter int SEED_WORDS = 4,
  parameter int NCH        = 2,
  parameter int SAMPLE_W   = 48,
  parameter int ADDR_W     = 6,
  parameter int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_calc,
  input  logic [1:0]               mode,
  input  logic [CW-1:0]            chan,
  input  logic [7:0]               i,
  input  logic [7:0]               j,
  input  logic [W-1:0]             in,
  input  logic                     in_valid,
  input  logic                     is_last,
  output logic                     in_ack,
  output logic [W-1:0]             k_in,
  output logic                     k_in_valid,
  output logic                     k_is_last,
  output logic [3:0]               k_last_bytes,
  input  logic                     k_ack,
  input  logic [W-1:0]             k_out,
  input  logic                     k_out_valid,
  output logic                     k_gimme,
  output logic [NCH-1:0]           s_in_valid,
  input  logic [NCH-1:0]           s_gimme,
  input  logic [NCH-1:0]           s_done,
  input  logic [NCH-1:0]           s_finish,
  input  logic [NCH*SAMPLE_W-1:0]  s_out,
  input  logic [NCH*ADDR_W-1:0]    s_addr,
  output logic [SAMPLE_W-1:0]      out_sample,
  output logic                     out_sample_valid,
  output logic [ADDR_W-1:0]        SRAM_address,
  output logic                     seed_ready,
  output logic                     busy,
  output logic                     err
);
  localparam int SW2 = 2 * SEED_WORDS;
  localparam int PW  = $clog2(SW2);
  localparam int AW  = $clog2(SEED_WORDS + 1);
  typedef enum logic [2:0] {IDLE, PASS, LOAD, ABSORB, SQUEEZE} state_t;
  state_t          r_state;
  logic [1:0]      r_mode;
  logic [CW-1:0]   r_chan;
  logic [7:0]      r_i, r_j;
  logic [W-1:0]    r_seed [SW2];
  logic [PW-1:0]   r_ptr;
  logic [AW-1:0]   r_wptr;
  logic            r_seed_ready, r_err;
  logic            w_ext, w_ab, w_sq, w_nonce, w_reject;
  logic [PW-1:0]   w_sidx;
  logic [W-1:0]    w_nonce_word;
  assign w_ext        = r_state == PASS || r_state == LOAD;
  assign w_ab         = r_state == ABSORB;
  assign w_sq         = r_state == SQUEEZE;
  assign w_nonce      = w_ab && r_wptr == AW'(SEED_WORDS);
  // mode 3 reads the sigma half; the index is unused on the nonce word
  assign w_sidx       = PW'(r_wptr) + (r_mode[0] ? PW'(SEED_WORDS) : PW'(0));
  assign w_nonce_word = r_mode[0] ? W'(r_i) : W'({r_j, r_i});
  assign w_reject     = start_calc && (r_state != IDLE || (mode[1] && !r_seed_ready));
  assign busy             = r_state != IDLE;
  assign seed_ready       = r_seed_ready;
  assign err              = r_err;
  assign in_ack           = w_ext && k_ack;
  assign k_in             = w_ext ? in : w_nonce ? w_nonce_word : w_ab ? r_seed[w_sidx] : '0;
  assign k_in_valid       = w_ext ? in_valid : w_ab;
  assign k_is_last        = w_ext ? is_last : w_nonce;
  assign k_last_bytes     = w_nonce ? (r_mode[0] ? 4'd1 : 4'd2) : 4'd8;
  assign k_gimme          = r_state == LOAD || (w_sq && s_gimme[r_chan]);
  assign s_in_valid       = (w_sq && k_out_valid) ? NCH'(1) << r_chan : '0;
  assign out_sample       = w_sq ? s_out[r_chan*SAMPLE_W +: SAMPLE_W] : '0;
  assign out_sample_valid = w_sq && s_done[r_chan];
  assign SRAM_address     = w_sq ? s_addr[r_chan*ADDR_W +: ADDR_W] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state      <= IDLE;
      r_mode       <= '0;
      r_chan       <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_ptr        <= '0;
      r_wptr       <= '0;
      r_seed_ready <= 1'b0;
      r_err        <= 1'b0;
      for (int k = 0; k < SW2; k++) r_seed[k] <= '0;
    end else begin
      r_err <= w_reject;
      case (r_state)
        IDLE: if (start_calc) begin
          r_mode <= mode;
          r_chan <= chan;
          r_i    <= i;
          r_j    <= j;
          if (mode == 2'd0) r_state <= PASS;
          else if (mode == 2'd1) begin
            r_state      <= LOAD;
            r_ptr        <= '0;
            r_seed_ready <= 1'b0;
          end else if (r_seed_ready) begin
            r_state <= ABSORB;
            r_wptr  <= '0;
          end
        end
        PASS: if (in_valid && is_last && k_ack) r_state <= IDLE;
        LOAD: if (k_out_valid) begin
          r_seed[r_ptr] <= k_out;
          r_ptr         <= r_ptr + 1'b1;
          if (r_ptr == PW'(SW2 - 1)) begin
            r_seed_ready <= 1'b1;
            r_state      <= IDLE;
          end
        end
        ABSORB: if (k_ack) begin
          if (w_nonce) r_state <= SQUEEZE;
          else r_wptr <= r_wptr + 1'b1;
        end
        SQUEEZE: if (s_finish[r_chan]) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hash_seq_ctrl.sv
// tb_hash_seq_ctrl: directed vector tables plus randomized load/absorb/squeeze
// rounds checked against a queue-based reference model.
module tb_hash_seq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start_calc, in_valid, is_last, in_ack, k_in_valid, k_is_last, k_ack;
  logic k_out_valid, k_gimme, out_sample_valid, seed_ready, busy, err;
  logic [1:0] mode, s_in_valid, s_gimme, s_done, s_finish;
  logic [0:0] chan;
  logic [7:0] ni, nj;
  logic [63:0] in_w, k_in, k_out;
  logic [3:0] k_last_bytes;
  logic [95:0] s_out;
  logic [11:0] s_addr;
  logic [47:0] out_sample;
  logic [5:0] SRAM_address;
  hash_seq_ctrl dut (
    .clk(clk), .rst(rst), .start_calc(start_calc), .mode(mode), .chan(chan),
    .i(ni), .j(nj), .in(in_w), .in_valid(in_valid), .is_last(is_last), .in_ack(in_ack),
    .k_in(k_in), .k_in_valid(k_in_valid), .k_is_last(k_is_last), .k_last_bytes(k_last_bytes),
    .k_ack(k_ack), .k_out(k_out), .k_out_valid(k_out_valid), .k_gimme(k_gimme),
    .s_in_valid(s_in_valid), .s_gimme(s_gimme), .s_done(s_done), .s_finish(s_finish),
    .s_out(s_out), .s_addr(s_addr), .out_sample(out_sample), .out_sample_valid(out_sample_valid),
    .SRAM_address(SRAM_address), .seed_ready(seed_ready), .busy(busy), .err(err)
  );
  typedef struct { logic ack; logic [63:0] kin; logic last; logic [3:0] lb; } vec_t;
  vec_t tbl [14];
  int checks = 0, errors = 0;
  logic [63:0] m_seed [8];
  logic [63:0] ld [8];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic idle_inputs;
    start_calc = 0; mode = 0; chan = 0; ni = 0; nj = 0; in_w = 0; in_valid = 0; is_last = 0;
    k_ack = 0; k_out = 0; k_out_valid = 0; s_gimme = 0; s_done = 0; s_finish = 0; s_out = 0; s_addr = 0;
  endtask
  task automatic start(input logic [1:0] m, input logic c, input logic [7:0] a, input logic [7:0] b);
    start_calc = 1; mode = m; chan = c; ni = a; nj = b;
    tick;
    start_calc = 0;
  endtask
  task automatic load_seed(input bit gaps, input bit clash);
    start(1, 0, 0, 0);
    #1;
    chk("load_busy", busy, 1);
    chk("load_ready_clr", seed_ready, 0);
    chk("load_gimme", k_gimme, 1);
    k_ack = 1;
    #1 chk("load_in_ack", in_ack, 1);
    k_ack = 0;
    for (int k = 0; k < 8; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick;
      k_out = ld[k];
      k_out_valid = 1;
      if (k == 7 && clash) begin start_calc = 1; mode = 2; end
      tick;
      k_out_valid = 0; start_calc = 0; mode = 0;
    end
    chk("load_ready", seed_ready, 1);
    chk("load_done_busy", busy, 0);
    chk("load_clash_err", err, clash);
    for (int k = 0; k < 8; k++) m_seed[k] = ld[k];
    tick;
    chk("load_err_pulse", err, 0);
  endtask
  task automatic apply(input int lo, input int hi);
    for (int r = lo; r < hi; r++) begin
      k_ack = tbl[r].ack;
      #1;
      chk("tbl_kin", k_in, tbl[r].kin);
      chk("tbl_valid", k_in_valid, 1);
      chk("tbl_last", k_is_last, tbl[r].last);
      chk("tbl_lb", k_last_bytes, tbl[r].lb);
      tick;
    end
    k_ack = 0;
    chk("tbl_sq_busy", busy, 1);
  endtask
  task automatic run_absorb(input logic [1:0] m, input logic c, input logic [7:0] a,
                            input logic [7:0] b, input int ackm, input bit inj);
    logic [63:0] q [$];
    int cyc = 0;
    bit pend;
    start(m, c, a, b);
    #1 chk("ab_busy", busy, 1);
    for (int k = 0; k < 4; k++) q.push_back(m_seed[k + (m == 3 ? 4 : 0)]);
    q.push_back(m == 2 ? {48'h0, b, a} : {56'h0, a});
    while (q.size() > 0 && cyc < 60) begin
      k_ack = ackm == 0 ? 1'b1 : ackm == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (inj && cyc == 1) begin start_calc = 1; mode = 1; chan = ~c; ni = 8'hEE; nj = 8'hDD; end
      #1;
      chk("ab_kin", k_in, q[0]);
      chk("ab_valid", k_in_valid, 1);
      chk("ab_last", k_is_last, q.size() == 1);
      chk("ab_lb", k_last_bytes, q.size() == 1 ? (m == 2 ? 2 : 1) : 8);
      chk("ab_inack", in_ack, 0);
      pend = start_calc;
      tick;
      start_calc = 0; mode = m; chan = c; ni = a; nj = b;
      if (k_ack) void'(q.pop_front());
      chk("ab_err", err, pend);
      cyc++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL ab_timeout: %0d words left, required 0", q.size());
    end
    k_ack = 0;
    #1;
    chk("ab_sq_busy", busy, 1);
    chk("ab_sq_kvalid", k_in_valid, 0);
    chk("ab_ready_kept", seed_ready, 1);
  endtask
  task automatic run_squeeze(input logic c, input int n);
    logic [47:0] smp [2];
    logic [5:0] adr [2];
    for (int k = 0; k < n; k++) begin
      for (int h = 0; h < 2; h++) begin
        smp[h] = {$urandom, $urandom};
        adr[h] = 6'($urandom);
      end
      s_out = {smp[1], smp[0]};
      s_addr = {adr[1], adr[0]};
      s_gimme = 2'($urandom); s_done = 2'($urandom); s_finish = 2'($urandom); s_finish[c] = 0;
      k_out_valid = 1'($urandom_range(0, 1));
      #1;
      chk("sq_gimme", k_gimme, s_gimme[c]);
      chk("sq_in_valid", s_in_valid, k_out_valid ? (c ? 2'b10 : 2'b01) : 2'b00);
      chk("sq_sample", out_sample, smp[c]);
      chk("sq_sample_valid", out_sample_valid, s_done[c]);
      chk("sq_addr", SRAM_address, adr[c]);
      tick;
      chk("sq_stay", busy, 1);
    end
    s_finish = 0;
    s_finish[c] = 1;
    tick;
    s_finish = 0;
    chk("sq_fin_busy", busy, 0);
    s_done = '1; k_out_valid = 1; s_gimme = '1; s_out = '1; s_addr = '1;
    #1;
    chk("idle_osv", out_sample_valid, 0);
    chk("idle_siv", s_in_valid, 0);
    chk("idle_gimme", k_gimme, 0);
    chk("idle_addr", SRAM_address, 0);
    chk("idle_sample", out_sample, 0);
    s_done = 0; k_out_valid = 0; s_gimme = 0; s_out = 0; s_addr = 0;
  endtask
  initial begin
    tbl[0]  = '{1'b1, 64'h11, 1'b0, 4'd8};
    tbl[1]  = '{1'b1, 64'h22, 1'b0, 4'd8};
    tbl[2]  = '{1'b1, 64'h33, 1'b0, 4'd8};
    tbl[3]  = '{1'b1, 64'h44, 1'b0, 4'd8};
    tbl[4]  = '{1'b1, 64'h0503, 1'b1, 4'd2};
    tbl[5]  = '{1'b1, 64'h55, 1'b0, 4'd8};
    tbl[6]  = '{1'b0, 64'h66, 1'b0, 4'd8};
    tbl[7]  = '{1'b1, 64'h66, 1'b0, 4'd8};
    tbl[8]  = '{1'b0, 64'h77, 1'b0, 4'd8};
    tbl[9]  = '{1'b1, 64'h77, 1'b0, 4'd8};
    tbl[10] = '{1'b0, 64'h88, 1'b0, 4'd8};
    tbl[11] = '{1'b1, 64'h88, 1'b0, 4'd8};
    tbl[12] = '{1'b0, 64'h07, 1'b1, 4'd1};
    tbl[13] = '{1'b1, 64'h07, 1'b1, 4'd1};
    idle_inputs();
    rst = 1;
    repeat (2) tick;
    chk("rst_busy", busy, 0);
    chk("rst_ready", seed_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_kvalid", k_in_valid, 0);
    chk("rst_klast", k_is_last, 0);
    chk("rst_gimme", k_gimme, 0);
    chk("rst_kin", k_in, 0);
    chk("rst_lb", k_last_bytes, 8);
    chk("rst_osv", out_sample_valid, 0);
    chk("rst_addr", SRAM_address, 0);
    chk("rst_siv", s_in_valid, 0);
    chk("rst_inack", in_ack, 0);
    rst = 0;
    tick;
    start(2, 0, 3, 5);
    #1;
    chk("noseed_busy", busy, 0);
    chk("noseed_err", err, 1);
    tick;
    chk("noseed_err_clr", err, 0);
    start(0, 0, 0, 0);
    in_w = 64'hDEAD_BEEF_0123_4567; in_valid = 1;
    #1;
    chk("pass_busy", busy, 1);
    chk("pass_kin", k_in, 64'hDEAD_BEEF_0123_4567);
    chk("pass_valid", k_in_valid, 1);
    chk("pass_gimme", k_gimme, 0);
    chk("pass_inack0", in_ack, 0);
    tick;
    k_ack = 1; is_last = 1;
    #1;
    chk("pass_inack1", in_ack, 1);
    chk("pass_last", k_is_last, 1);
    tick;
    chk("pass_done", busy, 0);
    in_valid = 0; is_last = 0; k_ack = 0; in_w = 0;
    for (int k = 0; k < 8; k++) ld[k] = 64'h11 * (k + 1);
    load_seed(0, 1);
    start(2, 1, 8'h03, 8'h05);
    apply(0, 5);
    k_out_valid = 1;
    #1 chk("m2_siv", s_in_valid, 2'b10);
    k_out_valid = 0;
    s_finish = 2'b10;
    tick;
    s_finish = 0;
    chk("m2_done", busy, 0);
    start(3, 0, 8'h07, 8'h00);
    apply(5, 14);
    s_done = 2'b01; s_addr = {6'h00, 6'h2A}; s_finish = 2'b10;
    #1;
    chk("sq0_osv", out_sample_valid, 1);
    chk("sq0_addr", SRAM_address, 6'h2A);
    tick;
    chk("sq0_other_fin", busy, 1);
    s_done = 0;
    #1 chk("sq0_osv_follow", out_sample_valid, 0);
    s_finish = 2'b01;
    tick;
    s_finish = 0; s_addr = 0;
    chk("sq0_fin", busy, 0);
    run_absorb(2, 1, 8'hA5, 8'h5A, 0, 1);
    run_squeeze(1, 3);
    start(3, 0, 8'h01, 8'h00);
    k_ack = 1;
    tick;
    #2 rst = 1;
    #1;
    chk("arst_kvalid", k_in_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", seed_ready, 0);
    chk("arst_kin", k_in, 0);
    chk("arst_lb", k_last_bytes, 8);
    chk("arst_gimme", k_gimme, 0);
    k_ack = 0;
    tick;
    rst = 0;
    tick;
    chk("arst_idle", busy, 0);
    start(2, 0, 8'h01, 8'h01);
    chk("arst_noseed_err", err, 1);
    chk("arst_noseed_busy", busy, 0);
    tick;
    repeat (25) begin
      for (int k = 0; k < 8; k++) ld[k] = {$urandom, $urandom};
      load_seed(1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 3)) begin
        logic [1:0] m;
        logic c;
        m = 2'($urandom_range(2, 3));
        c = 1'($urandom_range(0, 1));
        run_absorb(m, c, 8'($urandom), 8'($urandom), 2, $urandom_range(0, 3) == 0);
        run_squeeze(c, $urandom_range(0, 5));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
